// File: rtl/instr_decode_pkg.sv
// ============================================================================
//  Module   : instr_decode_pkg
//  Purpose  : Shared opcodes, ALU function codes, sequencer states and the
//             decoded control word for the instr_decode_seq fetch/decode block.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_decode_pkg;

    localparam int INSTR_W = 10;

    // Instruction field bit positions
    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int DR_MSB = 5;
    localparam int DR_LSB = 4;
    localparam int SA_MSB = 3;
    localparam int SA_LSB = 2;
    localparam int SB_MSB = 1;
    localparam int SB_LSB = 0;

    localparam logic [3:0] OP_MOVA = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_DEC  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_LDI  = 4'hB;
    localparam logic [3:0] OP_ADI  = 4'hC;
    localparam logic [3:0] OP_BRZ  = 4'hD;
    localparam logic [3:0] OP_BRN  = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hF;

    localparam logic [3:0] FS_MOVA = 4'h0;
    localparam logic [3:0] FS_INC  = 4'h1;
    localparam logic [3:0] FS_ADD  = 4'h2;
    localparam logic [3:0] FS_SUB  = 4'h5;
    localparam logic [3:0] FS_DEC  = 4'h6;
    localparam logic [3:0] FS_AND  = 4'h8;
    localparam logic [3:0] FS_OR   = 4'h9;
    localparam logic [3:0] FS_XOR  = 4'hA;
    localparam logic [3:0] FS_NOT  = 4'hB;
    localparam logic [3:0] FS_MOVB = 4'hC;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;

    typedef struct packed {
        logic       pl;
        logic       jb;
        logic       bc;
        logic [1:0] laddr;
        logic [1:0] raddr;
        logic [1:0] da;
        logic [1:0] aa;
        logic [1:0] ba;
        logic [3:0] fs;
        logic       mb;
        logic       md;
        logic       rw;
        logic       mw;
        logic [3:0] opnd;
    } ctrl_t;

    // ALU function code for the plain register-to-register opcodes 0..8
    function automatic logic [3:0] alu_fs(input logic [3:0] op);
        logic [3:0] fs;
        fs = FS_MOVA;
        case (op)
            OP_INC:  fs = FS_INC;
            OP_ADD:  fs = FS_ADD;
            OP_SUB:  fs = FS_SUB;
            OP_DEC:  fs = FS_DEC;
            OP_AND:  fs = FS_AND;
            OP_OR:   fs = FS_OR;
            OP_XOR:  fs = FS_XOR;
            OP_NOT:  fs = FS_NOT;
            default: fs = FS_MOVA;
        endcase
        return fs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_field_decode.sv
// ============================================================================
//  Module   : instr_field_decode
//  Purpose  : Combinational opcode/field decode into the control word.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_field_decode
    import instr_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output ctrl_t              o_ctrl
);

    logic [3:0] w_op;
    logic [1:0] w_dr;
    logic [1:0] w_sa;
    logic [1:0] w_sb;

    assign w_op = i_instr[OP_MSB:OP_LSB];
    assign w_dr = i_instr[DR_MSB:DR_LSB];
    assign w_sa = i_instr[SA_MSB:SA_LSB];
    assign w_sb = i_instr[SB_MSB:SB_LSB];

    always_comb begin
        o_ctrl       = '0;
        // Register selects and offsets follow the fields for every opcode
        o_ctrl.da    = w_dr;
        o_ctrl.aa    = w_sa;
        o_ctrl.ba    = w_sb;
        o_ctrl.laddr = w_dr;
        o_ctrl.raddr = w_sb;
        o_ctrl.opnd  = {2'b00, w_sb};
        case (w_op)
            OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC,
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                o_ctrl.rw = 1'b1;
                o_ctrl.fs = alu_fs(w_op);
            end
            OP_LD: begin
                o_ctrl.rw = 1'b1;
                o_ctrl.md = 1'b1;
                o_ctrl.fs = FS_MOVA;
            end
            OP_ST: begin
                o_ctrl.mw = 1'b1;
            end
            OP_LDI: begin
                o_ctrl.rw = 1'b1;
                o_ctrl.mb = 1'b1;
                o_ctrl.fs = FS_MOVB;
            end
            OP_ADI: begin
                o_ctrl.rw = 1'b1;
                o_ctrl.mb = 1'b1;
                o_ctrl.fs = FS_ADD;
            end
            OP_BRZ: begin
                o_ctrl.pl = 1'b1;
                o_ctrl.fs = FS_MOVA;
            end
            OP_BRN: begin
                o_ctrl.pl = 1'b1;
                o_ctrl.bc = 1'b1;
                o_ctrl.fs = FS_MOVA;
            end
            OP_JMP: begin
                o_ctrl.pl = 1'b1;
                o_ctrl.jb = 1'b1;
                o_ctrl.fs = FS_MOVA;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_decode_seq.sv
// ============================================================================
//  Module   : instr_decode_seq
//  Purpose  : FETCH -> WAIT -> EXEC sequencer: reads instruction memory at PC,
//             latches the word and issues registered controls for one cycle.
//             Optional halt support under `INSTR_DECODE_HALT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_decode_seq
    import instr_decode_pkg::*;
#(
    parameter int IMEM_LATENCY = 1,
    parameter int IW           = 10
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [3:0]    PC,
    output logic [3:0]    IMEM_ADDR,
    output logic          IMEM_RE,
    input  logic [IW-1:0] IMEM_DATA,
    output logic          PL,
    output logic          JB,
    output logic          BC,
    output logic [1:0]    LAddress,
    output logic [1:0]    RAddress,
    output logic [1:0]    DA,
    output logic [1:0]    AA,
    output logic [1:0]    BA,
    output logic [3:0]    FS,
    output logic          MB,
    output logic          MD,
    output logic          RW,
    output logic          MW,
    output logic [3:0]    OPND,
    output logic          PC_EN,
`ifdef INSTR_DECODE_HALT_EN
    input  logic          HALT,
    output logic          HALTED,
`endif
    output logic [IW-1:0] INSTR
);

    localparam logic [1:0] c_wait_last = 2'(IMEM_LATENCY - 1);

    logic [2:0]    r_state;
    logic [1:0]    r_wait_cnt;
    logic [3:0]    r_addr;
    logic [IW-1:0] r_ir;
    ctrl_t         r_ctrl;
    logic          r_pc_en;
    ctrl_t         w_dec;

    instr_field_decode u_dec (
        .i_instr (IMEM_DATA[INSTR_W-1:0]),
        .o_ctrl  (w_dec)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 2'd0;
            r_addr     <= 4'd0;
            r_ir       <= '0;
            r_ctrl     <= '0;
            r_pc_en    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_addr     <= PC;
                    r_wait_cnt <= 2'd0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == c_wait_last) begin
                        r_ir    <= IMEM_DATA;
                        r_ctrl  <= w_dec;
                        r_pc_en <= 1'b1;
                        r_state <= ST_EXEC;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                ST_EXEC: begin
                    r_ctrl  <= '0;
                    r_pc_en <= 1'b0;
`ifdef INSTR_DECODE_HALT_EN
                    r_state <= HALT ? ST_HALTED : ST_FETCH;
`else
                    r_state <= ST_FETCH;
`endif
                end
                ST_HALTED: begin
`ifdef INSTR_DECODE_HALT_EN
                    if (!HALT) begin
                        r_state <= ST_FETCH;
                    end
`else
                    r_state <= ST_FETCH;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // During FETCH the address follows PC so the memory sees it in the RE cycle;
    // the captured value then holds through WAIT.
    assign IMEM_ADDR = (r_state == ST_FETCH) ? PC : r_addr;
    assign IMEM_RE   = (r_state == ST_FETCH);

`ifdef INSTR_DECODE_HALT_EN
    assign HALTED    = (r_state == ST_HALTED);
`endif

    assign PL       = r_ctrl.pl;
    assign JB       = r_ctrl.jb;
    assign BC       = r_ctrl.bc;
    assign LAddress = r_ctrl.laddr;
    assign RAddress = r_ctrl.raddr;
    assign DA       = r_ctrl.da;
    assign AA       = r_ctrl.aa;
    assign BA       = r_ctrl.ba;
    assign FS       = r_ctrl.fs;
    assign MB       = r_ctrl.mb;
    assign MD       = r_ctrl.md;
    assign RW       = r_ctrl.rw;
    assign MW       = r_ctrl.mw;
    assign OPND     = r_ctrl.opnd;
    assign PC_EN    = r_pc_en;
    assign INSTR    = r_ir;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_seq.sv
// ============================================================================
//  Module   : tb_instr_decode_seq
//  Purpose  : Directed self-checking bench for instr_decode_seq (latency 1 and
//             latency 3 instances; halt checks when INSTR_DECODE_HALT_EN set).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_decode_seq;

    logic       CLK;
    logic       RSTn;
    logic [3:0] PC;
    logic [9:0] IMEM_DATA;
    logic       HALT_IN;

    logic [3:0] IMEM_ADDR, FS, OPND;
    logic       IMEM_RE, PL, JB, BC, MB, MD, RW, MW, PC_EN;
    logic [1:0] LAddress, RAddress, DA, AA, BA;
    logic [9:0] INSTR;

    logic [3:0] addr3, fs3, opnd3;
    logic       re3, pl3, jb3, bc3, mb3, md3, rw3, mw3, pc_en3;
    logic [1:0] la3, ra3, da3, aa3, ba3;
    logic [9:0] instr3;

`ifdef INSTR_DECODE_HALT_EN
    logic       HALTED;
    logic       halted3;
    logic       halt3_tie;
`endif

    int n_cmp = 0;
    int n_err = 0;

    instr_decode_seq #(.IMEM_LATENCY(1), .IW(10)) u_dut (
        .CLK(CLK), .RSTn(RSTn), .PC(PC), .IMEM_ADDR(IMEM_ADDR), .IMEM_RE(IMEM_RE),
        .IMEM_DATA(IMEM_DATA), .PL(PL), .JB(JB), .BC(BC), .LAddress(LAddress),
        .RAddress(RAddress), .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB), .MD(MD),
        .RW(RW), .MW(MW), .OPND(OPND), .PC_EN(PC_EN),
`ifdef INSTR_DECODE_HALT_EN
        .HALT(HALT_IN), .HALTED(HALTED),
`endif
        .INSTR(INSTR)
    );

    instr_decode_seq #(.IMEM_LATENCY(3), .IW(10)) u_dut3 (
        .CLK(CLK), .RSTn(RSTn), .PC(PC), .IMEM_ADDR(addr3), .IMEM_RE(re3),
        .IMEM_DATA(IMEM_DATA), .PL(pl3), .JB(jb3), .BC(bc3), .LAddress(la3),
        .RAddress(ra3), .DA(da3), .AA(aa3), .BA(ba3), .FS(fs3), .MB(mb3), .MD(md3),
        .RW(rw3), .MW(mw3), .OPND(opnd3), .PC_EN(pc_en3),
`ifdef INSTR_DECODE_HALT_EN
        .HALT(halt3_tie), .HALTED(halted3),
`endif
        .INSTR(instr3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present a word and advance until the EXEC cycle (bounded)
    task automatic exec_instr(input logic [9:0] word);
        IMEM_DATA = word;
        step();
        for (int i = 0; i < 8 && PC_EN !== 1'b1; i++) step();
        check("exec_reached", PC_EN, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f1re, f1ex, f3re, f3ex, re3_pre, pe1_cnt, pe3_cnt, pe_cnt;
`ifdef INSTR_DECODE_HALT_EN
        halt3_tie = 1'b0;
`endif
        HALT_IN   = 1'b0;
        RSTn      = 1'b0;
        PC        = 4'd5;
        IMEM_DATA = 10'h09B;
        step();
        step();
        check("rst_re",    IMEM_RE, 0);
        check("rst_addr",  IMEM_ADDR, 0);
        check("rst_pc_en", PC_EN, 0);
        check("rst_rw",    RW, 0);
        check("rst_instr", INSTR, 0);
        RSTn = 1'b1;

        // ADD R1,R2,R3
        step();
        check("fetch_re",   IMEM_RE, 1);
        check("fetch_addr", IMEM_ADDR, 5);
        check("fetch_pcen", PC_EN, 0);
        exec_instr(10'h09B);
        check("add_rw", RW, 1);
        check("add_da", DA, 1);
        check("add_aa", AA, 2);
        check("add_ba", BA, 3);
        check("add_fs", FS, 2);
        check("add_pl", PL, 0);
        check("add_instr", INSTR, 10'h09B);
        IMEM_DATA = 10'h3FF;
        step();
        check("nop_rw",    RW, 0);
        check("nop_pcen",  PC_EN, 0);
        check("nop_da",    DA, 0);
        check("nop_fs",    FS, 0);
        check("hold_instr", INSTR, 10'h09B);

        // BRZ
        exec_instr(10'h371);
        check("brz_pl", PL, 1);
        check("brz_jb", JB, 0);
        check("brz_bc", BC, 0);
        check("brz_la", LAddress, 3);
        check("brz_ra", RAddress, 1);
        check("brz_rw", RW, 0);

        // JMP R2
        exec_instr(10'h3C8);
        check("jmp_pl", PL, 1);
        check("jmp_jb", JB, 1);
        check("jmp_aa", AA, 2);
        check("jmp_fs", FS, 0);

        // BRN
        exec_instr(10'h39B);
        check("brn_bc", BC, 1);
        check("brn_pl", PL, 1);
        check("brn_jb", JB, 0);

        // ST, LD, SUB, NOT, LDI, ADI
        exec_instr(10'h286);
        check("st_mw", MW, 1);
        check("st_rw", RW, 0);
        exec_instr(10'h264);
        check("ld_rw", RW, 1);
        check("ld_md", MD, 1);
        check("ld_fs", FS, 0);
        exec_instr(10'h0C0);
        check("sub_fs", FS, 5);
        exec_instr(10'h200);
        check("not_fs", FS, 4'hB);
        exec_instr(10'h2D3);
        check("ldi_fs",   FS, 4'hC);
        check("ldi_mb",   MB, 1);
        check("ldi_opnd", OPND, 3);
        exec_instr(10'h302);
        check("adi_fs",   FS, 2);
        check("adi_mb",   MB, 1);
        check("adi_opnd", OPND, 2);

        // Asynchronous reset while in WAIT
        step();
        step();
        #2 RSTn = 1'b0;
        #1;
        check("arst_re",    IMEM_RE, 0);
        check("arst_addr",  IMEM_ADDR, 0);
        check("arst_instr", INSTR, 0);
        check("arst_pcen",  PC_EN, 0);
        step();
        RSTn = 1'b1;
        step();
        check("refetch_re",   IMEM_RE, 1);
        check("refetch_addr", IMEM_ADDR, 5);
        pe_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (PC_EN === 1'b1) pe_cnt++;
        end
        check("refetch_pcen_once", pe_cnt, 1);

        // Latency: 1-latency and 3-latency instances from a common reset
        RSTn = 1'b0;
        step();
        step();
        RSTn = 1'b1;
        f1re = -1; f1ex = -1; f3re = -1; f3ex = -1;
        re3_pre = 0; pe1_cnt = 0; pe3_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (IMEM_RE === 1'b1 && f1re < 0) f1re = i;
            if (PC_EN === 1'b1 && f1ex < 0) f1ex = i;
            if (PC_EN === 1'b1) pe1_cnt++;
            if (re3 === 1'b1 && f3ex < 0) re3_pre++;
            if (re3 === 1'b1 && f3re < 0) f3re = i;
            if (pc_en3 === 1'b1 && f3ex < 0) f3ex = i;
            if (pc_en3 === 1'b1) pe3_cnt++;
        end
        check("lat1_first_fetch", f1re, 0);
        check("lat1_exec_gap",    f1ex - f1re, 2);
        check("lat1_pcen_count",  pe1_cnt, 4);
        check("lat3_first_fetch", f3re, 0);
        check("lat3_exec_gap",    f3ex - f3re, 4);
        check("lat3_re_once",     re3_pre, 1);
        check("lat3_pcen_count",  pe3_cnt, 2);

`ifdef INSTR_DECODE_HALT_EN
        step();
        HALT_IN = 1'b1;
        exec_instr(10'h2D3);
        check("halt_ldi_opnd", OPND, 3);
        check("halt_ldi_mb",   MB, 1);
        check("halt_ldi_rw",   RW, 1);
        step();
        check("halted_1",    HALTED, 1);
        check("halted_re",   IMEM_RE, 0);
        check("halted_rw",   RW, 0);
        step();
        step();
        check("halted_hold", HALTED, 1);
        check("halted_re2",  IMEM_RE, 0);
        HALT_IN = 1'b0;
        step();
        check("resume_re",     IMEM_RE, 1);
        check("resume_halted", HALTED, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
